// File: rtl/uart_transmit.sv
// 8-bit UART transmitter: one-entry holding register feeding a shift register, framed as
// start, D0..D7 (LSB first), optional parity, then one or two stop bits, paced by transmit_baud.
module uart_transmit #(
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       transmit_baud,
    input  logic       transmit_write_en,
    input  logic [7:0] transmit_write_line,
    output logic       txd,
    output logic       tbr,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overrun
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

    state_e     r_state, w_state_d;
    logic [7:0] r_hold, w_hold_d;
    logic       r_hold_full, w_hold_full_d;
    logic [7:0] r_shift, w_shift_d;
    logic [2:0] r_bit_cnt, w_bit_cnt_d;
    logic       r_parity, w_parity_d;
    logic       r_txd, w_txd_d;
    logic       r_busy, w_busy_d;
    logic       r_done, w_done_d;
    logic       r_overrun, w_overrun_d;
    logic       w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_hold      <= w_hold_d;
            r_hold_full <= w_hold_full_d;
            r_shift     <= w_shift_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_parity    <= w_parity_d;
            r_txd       <= w_txd_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_overrun   <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;
        w_shift_d     = r_shift;
        w_bit_cnt_d   = r_bit_cnt;
        w_parity_d    = r_parity;
        w_txd_d       = r_txd;
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;
        w_overrun_d   = 1'b0;
        w_load        = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_txd_d = 1'b1;
                if (transmit_baud && r_hold_full) begin
                    w_load = 1'b1;
                end
            end
            StStart: begin
                if (transmit_baud) begin
                    w_txd_d     = r_shift[0];
                    w_shift_d   = r_shift >> 1;
                    w_bit_cnt_d = '0;
                    w_state_d   = StData;
                end
            end
            StData: begin
                if (transmit_baud) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            w_txd_d   = r_parity;
                            w_state_d = StParity;
                        end else begin
                            w_txd_d   = 1'b1;
                            w_state_d = StStop;
                        end
                    end else begin
                        w_txd_d     = r_shift[0];
                        w_shift_d   = r_shift >> 1;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                    end
                end
            end
            StParity: begin
                if (transmit_baud) begin
                    w_txd_d     = 1'b1;
                    w_bit_cnt_d = '0;
                    w_state_d   = StStop;
                end
            end
            StStop: begin
                if (transmit_baud) begin
                    if (r_bit_cnt == StopLast) begin
                        w_done_d    = 1'b1;
                        w_bit_cnt_d = '0;
                        // A queued byte starts its start bit on this same strobe: no idle gap.
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_d = StIdle;
                            w_busy_d  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_load) begin
            w_shift_d     = r_hold;
            w_parity_d    = (^r_hold) ^ (PARITY_ODD != 0);
            w_hold_full_d = 1'b0;
            w_bit_cnt_d   = '0;
            w_txd_d       = 1'b0;
            w_busy_d      = 1'b1;
            w_state_d     = StStart;
        end

        // A load only happens with the holding register full, so any coincident write is an overrun.
        if (transmit_write_en) begin
            if (r_hold_full) begin
                w_overrun_d = 1'b1;
            end else begin
                w_hold_d      = transmit_write_line;
                w_hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (STOP_BITS == 1 || STOP_BITS == 2)
            else $error("uart_transmit: STOP_BITS must be 1 or 2");
    end

    assign txd     = r_txd;
    assign tbr     = ~r_hold_full;
    assign tx_busy = r_busy;
    assign tx_done = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: three instances (default, even parity + 2 stop, odd parity
// + 2 stop) share clock, baud strobe (every 16 clks) and data bus; each has its own write enable.
module tb_uart_transmit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud;
    logic [2:0] we;
    logic [7:0] line;
    logic [2:0] txd, tbr, busy, done, ovr;

    int errors = 0;
    int checks = 0;
    int done0 = 0, done1 = 0, done2 = 0, ovr0 = 0;

    always #5 clk = ~clk;

    uart_transmit u_dut0 (
        .clk(clk), .rst_n(rst_n), .transmit_baud(baud), .transmit_write_en(we[0]),
        .transmit_write_line(line), .txd(txd[0]), .tbr(tbr[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .overrun(ovr[0])
    );

    uart_transmit #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .transmit_baud(baud), .transmit_write_en(we[1]),
        .transmit_write_line(line), .txd(txd[1]), .tbr(tbr[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .overrun(ovr[1])
    );

    uart_transmit #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .transmit_baud(baud), .transmit_write_en(we[2]),
        .transmit_write_line(line), .txd(txd[2]), .tbr(tbr[2]), .tx_busy(busy[2]),
        .tx_done(done[2]), .overrun(ovr[2])
    );

    initial begin
        baud = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done[0]) done0 <= done0 + 1;
        if (done[1]) done1 <= done1 + 1;
        if (done[2]) done2 <= done2 + 1;
        if (ovr[0])  ovr0  <= ovr0 + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        we    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input int sel, input logic [7:0] b);
        line    = b;
        we[sel] = 1'b1;
        @(negedge clk);
        we = '0;
    endtask

    task automatic wait_tbr(input int sel, output bit to);
        int n = 0;
        while (tbr[sel] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 100);
    endtask

    // Returns mid-bit samples of one frame; f[0] is the start bit.
    task automatic cap_frame(input int sel, input int nbits, output logic [11:0] f,
                             output bit to);
        int n = 0;
        f  = '0;
        to = 1'b0;
        while (txd[sel] !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            to = 1'b1;
            return;
        end
        repeat (8) @(negedge clk);
        f[0] = txd[sel];
        for (int i = 1; i < nbits; i++) begin
            repeat (16) @(negedge clk);
            f[i] = txd[sel];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = '0;
        line  = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({txd[s], tbr[s], busy[s], done[s], ovr[s]} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b, expected 11000", s,
                         {txd[s], tbr[s], busy[s], done[s], ovr[s]});
            end
        end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if ({txd[0], busy[0], tbr[0]} !== 3'b101) begin
            errors++;
            $display("FAIL idle_ignores_baud: got txd/busy/tbr=%b, expected 101",
                     {txd[0], busy[0], tbr[0]});
        end
    endtask

    task automatic test_frame_55();
        logic [9:0] exp_bits;
        int d0, n;
        exp_bits = {1'b1, 8'h55, 1'b0};
        do_reset();
        d0 = done0;
        wr(0, 8'h55);
        checks++;
        if (tbr[0] !== 1'b0) begin
            errors++;
            $display("FAIL tbr_after_write: got %b, expected 0", tbr[0]);
        end
        n = 0;
        while (txd[0] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL start_timeout: got no start bit, expected one within 40 clks");
        end
        checks++;
        if ({tbr[0], busy[0]} !== 2'b11) begin
            errors++;
            $display("FAIL tbr_busy_at_start: got %b, expected 11", {tbr[0], busy[0]});
        end
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (txd[0] !== exp_bits[i]) begin
                    errors++;
                    $display("FAIL frame55_bit%0d_clk%0d: got %b, expected %b", i, k, txd[0],
                             exp_bits[i]);
                end
                @(negedge clk);
            end
        end
        checks++;
        if ({txd[0], busy[0]} !== 2'b10) begin
            errors++;
            $display("FAIL frame55_end: got txd/busy=%b, expected 10", {txd[0], busy[0]});
        end
        @(negedge clk);
        checks++;
        if (done0 - d0 !== 1) begin
            errors++;
            $display("FAIL frame55_done: got %0d pulses, expected 1", done0 - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] f;
        bit to;
        int d0, o0;
        do_reset();
        d0 = done0;
        o0 = ovr0;
        wr(0, 8'hA5);
        @(negedge clk);
        wait_tbr(0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL b2b_tbr_timeout: got tbr=%b, expected 1", tbr[0]);
        end
        wr(0, 8'h3C);
        cap_frame(0, 10, f, to);
        checks++;
        if (to || f[9:0] !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL b2b_frame_a5: got %b (to=%0d), expected %b", f[9:0], to,
                     {1'b1, 8'hA5, 1'b0});
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({txd[0], busy[0]} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_no_gap: got txd/busy=%b, expected 01", {txd[0], busy[0]});
        end
        cap_frame(0, 10, f, to);
        checks++;
        if (to || f[9:0] !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL b2b_frame_3c: got %b (to=%0d), expected %b", f[9:0], to,
                     {1'b1, 8'h3C, 1'b0});
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done0 - d0 !== 2 || ovr0 !== o0) begin
            errors++;
            $display("FAIL b2b_counts: got done=%0d ovr=%0d, expected done=2 ovr=0",
                     done0 - d0, ovr0 - o0);
        end
    endtask

    task automatic test_overrun();
        logic [11:0] f;
        bit to;
        int d0, o0, n;
        do_reset();
        d0 = done0;
        o0 = ovr0;
        wr(0, 8'h11);
        n = 0;
        while (txd[0] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        line  = 8'h22;
        we[0] = 1'b1;
        @(negedge clk);
        line = 8'h33;
        @(negedge clk);
        we = '0;
        @(negedge clk);
        checks++;
        if (ovr0 - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d pulses, expected 1", ovr0 - o0);
        end
        cap_frame(0, 10, f, to);
        checks++;
        if (to || f[9:0] !== {1'b1, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL overrun_frame_11: got %b (to=%0d), expected %b", f[9:0], to,
                     {1'b1, 8'h11, 1'b0});
        end
        cap_frame(0, 10, f, to);
        checks++;
        if (to || f[9:0] !== {1'b1, 8'h22, 1'b0}) begin
            errors++;
            $display("FAIL overrun_frame_22: got %b (to=%0d), expected %b", f[9:0], to,
                     {1'b1, 8'h22, 1'b0});
        end
        repeat (40) @(negedge clk);
        checks++;
        if ({txd[0], busy[0], tbr[0]} !== 3'b101 || done0 - d0 !== 2 || ovr0 - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_idle_after: got txd/busy/tbr=%b done=%0d ovr=%0d, expected 101 2 1",
                     {txd[0], busy[0], tbr[0]}, done0 - d0, ovr0 - o0);
        end
    endtask

    task automatic test_parity();
        logic [11:0] f;
        bit to;
        int d1;
        do_reset();
        d1 = done1;
        wr(1, 8'h07);
        cap_frame(1, 12, f, to);
        checks++;
        if (to || f !== {2'b11, 1'b1, 8'h07, 1'b0}) begin
            errors++;
            $display("FAIL parity_even_frame: got %b (to=%0d), expected %b", f, to,
                     {2'b11, 1'b1, 8'h07, 1'b0});
        end
        checks++;
        if (busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL parity_second_stop_busy: got %b, expected 1", busy[1]);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0 || done1 - d1 !== 1) begin
            errors++;
            $display("FAIL parity_frame_end: got busy=%b done=%0d, expected busy=0 done=1",
                     busy[1], done1 - d1);
        end
        wr(2, 8'h07);
        cap_frame(2, 12, f, to);
        checks++;
        if (to || f !== {2'b11, 1'b0, 8'h07, 1'b0}) begin
            errors++;
            $display("FAIL parity_odd_frame: got %b (to=%0d), expected %b", f, to,
                     {2'b11, 1'b0, 8'h07, 1'b0});
        end
    endtask

    task automatic test_reset_midframe();
        int d0, n, bad;
        do_reset();
        wr(0, 8'h55);
        n = 0;
        while (txd[0] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        wr(0, 8'h99);
        repeat (16 * 4 + 6) @(negedge clk);
        checks++;
        if (txd[0] !== 1'b0 || tbr[0] !== 1'b0) begin
            errors++;
            $display("FAIL midframe_d3: got txd/tbr=%b, expected 00", {txd[0], tbr[0]});
        end
        d0 = done0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txd[0], tbr[0], busy[0]} !== 3'b110) begin
            errors++;
            $display("FAIL midframe_async_reset: got txd/tbr/busy=%b, expected 110",
                     {txd[0], tbr[0], busy[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || done0 !== d0) begin
            errors++;
            $display("FAIL midframe_stays_idle: got %0d active clks, done=%0d, expected 0 and 0",
                     bad, done0 - d0);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        logic [11:0] f;
        bit to;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h5A;
        do_reset();
        wr(0, bytes[0]);
        @(negedge clk);
        wait_tbr(0, to);
        wr(0, bytes[1]);
        for (int i = 0; i < 3; i++) begin
            cap_frame(0, 10, f, to);
            checks++;
            if (to || f[0] !== 1'b0 || f[9] !== 1'b1 || f[8:1] !== bytes[i]) begin
                errors++;
                $display("FAIL loopback_byte%0d: got data %h start %b stop %b (to=%0d), expected %h 0 1",
                         i, f[8:1], f[0], f[9], to, bytes[i]);
            end
            if (i == 0) begin
                wait_tbr(0, to);
                wr(0, bytes[2]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        we    = '0;
        line  = '0;
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_overrun();
        test_parity();
        test_reset_midframe();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- 8-bit asynchronous serial transmitter, the TX half of the board UART. Pairs with the existing receiver on the same link.
- Serialises one byte per frame onto txd, LSB first: start bit, data bits, optional parity bit, stop bit(s).
- Bit timing comes from an external baud generator strobe (transmit_baud), one strobe per bit time. This is the same strobe scheme the receiver uses.
- Contains a one-entry holding register and a shift register, so the host can queue the next byte while the current frame is on the wire.

Parameters:
- PARITY_EN, 0, 1 inserts a parity bit after D7; 0 means no parity bit.
- PARITY_ODD, 0, parity type when PARITY_EN=1: 0 even, 1 odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- transmit_baud  input  1  single-cycle strobe, one per bit period.
- transmit_write_en  input  1  host write strobe; qualified by tbr.
- transmit_write_line  input  8  byte to send; sampled when transmit_write_en=1 and tbr=1.
- txd  output  1  serial line; idles high.
- tbr  output  1  transmit buffer ready: holding register empty.
- tx_busy  output  1  high while any frame bit (start through last stop) is driven.
- tx_done  output  1  one-cycle pulse at the end of each frame.
- overrun  output  1  one-cycle pulse when a write arrives while tbr=0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame) drives these values:
  - txd=1, tbr=1, tx_busy=0, tx_done=0, overrun=0;
  - holding register cleared, state=IDLE, bit counter=0.
- Host write:
  - transmit_write_en=1 with tbr=1 loads the holding register at that clk edge; tbr reads 0 from the next cycle.
  - transmit_write_en=1 with tbr=0: data is discarded, overrun pulses for one cycle the next cycle, and holding-register contents are unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. The FSM waits for holding full AND transmit_baud=1. On that edge:
    - holding moves to the shift register;
    - tbr=1 and tx_busy=1 from the next cycle;
    - state goes to START, and txd=0 from the next cycle.
  - START: on transmit_baud, go to DATA; txd=D0.
  - DATA: on each transmit_baud, shift right and increment the bit counter. After the strobe that ends D7 (8 strobes in DATA), go to PARITY if PARITY_EN, else STOP.
  - PARITY: txd = XOR of D7..D0, inverted when PARITY_ODD=1. On transmit_baud, go to STOP.
  - STOP: txd=1 for STOP_BITS strobe periods. On the strobe that ends the last stop bit, tx_done pulses for one cycle and then:
    - if holding is full (including a write landing on that same edge? no: a same-edge write lands next cycle and is handled from IDLE), the transfer happens on that same strobe and the state goes directly to START, giving back-to-back frames with no idle gap;
    - otherwise the state goes to IDLE and tx_busy=0 from the next cycle.
- Bit timing: every bit, including start, spans exactly one strobe-to-strobe interval. txd changes only on the clk edge at which transmit_baud=1, or on reset. txd is a registered output with no glitches.
- transmit_baud is ignored in IDLE when holding is empty.
- Simultaneous write and transfer: not possible, because transfer requires holding full (tbr=0), so any such write is an overrun.
- Frame length in strobes: 1 start + 8 data + PARITY_EN + STOP_BITS.
- A transmit_write_line change while the frame is in flight has no effect; data is captured into the shift register at transfer.
- STOP_BITS values other than 1 or 2 are illegal; flag this with a simulation assertion.

Test Plan:
- Default params, strobe every 16 clks, write 0x55 in IDLE -> txd holds each of 0,1,0,1,0,1,0,1,0,1 for exactly 16 clks; tx_done pulses once; tbr=1 one cycle after the start-bit strobe.
- Write 0xA5, then write 0x3C as soon as tbr rises -> two frames back-to-back (start bit of 0x3C immediately follows the stop bit of 0xA5); tx_done pulses twice; no overrun.
- Write 0x11, then 0x22, then 0x33 with no tbr wait -> 0x33 dropped, overrun pulses once, only 0x11 and 0x22 appear on txd.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, write 0x07 -> parity bit 1, then 2 high stop bits; frame is 12 strobes. With PARITY_ODD=1 -> parity bit 0.
- Assert rst_n low during D3 of a frame -> txd=1 and tbr=1 immediately; after release, line stays idle and no tx_done.
- Loopback txd to the receiver's rxd with a shared baud, send 0x00, 0xFF, 0x5A -> receiver reports the identical bytes with rda set each time.
